spi_master_arbiter: RTL and testbench
=====================================

# spi_master_arbiter

Round-robin arbiter and sequencer that shares one `spi_master` instance among NUM_REQ on-chip requesters. It accepts per-requester transfer requests (target slave plus transmit word) and selects one winner at a time. It launches the transfer on the master, waits for the master's completion interrupt, and returns the received word with a one-cycle done pulse to the winning requester. It sits between the requester fabric and the `spi_master` control port.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 16, SPI word width; must match spi_master
- NUM_SLAVES, 4, number of slave selects; must match spi_master
- SLV_W, 2, width of a slave index; must satisfy 2^SLV_W >= NUM_SLAVES
- TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles (used only with SPI_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester request level
- req_slave  in  NUM_REQ*SLV_W  packed slave index; requester i occupies bits [i*SLV_W +: SLV_W]
- req_data  in  NUM_REQ*DATA_WIDTH  packed transmit words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- done  out  NUM_REQ  one-cycle completion pulse to the winner
- rsp_data  out  DATA_WIDTH  received word; valid in the done cycle and held until the next done
- err  out  1  one-cycle pulse coincident with done on a failed transaction
- spi_start  out  1  one-cycle start pulse, drives spi_master start_tx
- spi_tx_data  out  DATA_WIDTH  word for spi_master tx_data
- spi_slave_sel  out  NUM_SLAVES  one-hot slave enable, gates the spi_master ss_n lines
- spi_busy  in  1  spi_master busy
- spi_irq  in  1  spi_master completion pulse
- spi_rx_data  in  DATA_WIDTH  spi_master rx_data

## Operation
- States: IDLE, START, WAIT_DONE, FINISH. All outputs are registered.
- IDLE:
  - Arbitration occurs only when req != 0 and spi_busy == 0.
  - The winner is the first set req bit, searching upward from rr_ptr with wrap.
  - The winner's req_slave and req_data are latched. gnt[winner] is set.
  - Valid slave index: spi_tx_data and spi_slave_sel are loaded, then -> START.
  - Slave index >= NUM_SLAVES: no SPI activity. done[winner]=1, err=1, rsp_data unchanged, then -> FINISH.
- START: spi_start=1 for exactly one cycle, then -> WAIT_DONE.
- WAIT_DONE:
  - On spi_irq=1: rsp_data <= spi_rx_data, done[winner]=1, err=0, then -> FINISH.
  - spi_irq in any other state is ignored.
- FINISH:
  - gnt, spi_slave_sel, done and err clear.
  - rr_ptr <= (winner+1) mod NUM_REQ; this also applies to error completions.
  - Then -> IDLE.
- Request rules:
  - req must be held until done.
  - Deasserting req after grant does not abort; the transaction completes and done still pulses.
  - req_slave and req_data are sampled only in the grant cycle.
- Reset, asynchronous and usable mid-transaction:
  - state=IDLE, rr_ptr=0.
  - gnt, done, err, spi_start, spi_slave_sel, spi_tx_data and rsp_data are all 0.
  - spi_master shares rst_n, so no partial transfer survives.

## Timing
- req sampled high in IDLE at edge N: gnt, spi_tx_data and spi_slave_sel are valid after edge N.
- spi_start is high for the cycle after edge N+1. WAIT_DONE is entered at edge N+2.
- spi_irq sampled at edge M: done, rsp_data and err are valid after M+1 for one cycle.
- gnt drops after M+2.
- The next arbitration is sampled at M+3, giving back-to-back throughput of transfer time + 4 cycles.
- Invalid-slave rejection: done and err are valid after edge N; gnt drops after N+1.
- Simultaneous requests are served strictly in round-robin order from rr_ptr. No requester waits more than NUM_REQ-1 transactions.

## Configuration
- SPI_ARB_TIMEOUT_EN defined:
  - A cycle counter of width clog2(TIMEOUT_CYCLES+1) resets on entry to WAIT_DONE and increments each cycle there.
  - If it reaches TIMEOUT_CYCLES without spi_irq: done[winner]=1, err=1, rsp_data=0, then -> FINISH.
  - If spi_irq and timeout occur in the same cycle, spi_irq wins.
- SPI_ARB_TIMEOUT_EN undefined:
  - No counter. WAIT_DONE waits indefinitely for spi_irq.
  - err is raised only by an invalid slave index.

## Test plan
- Single request: req=4'b0001, req_slave[0]=2, req_data[0]=16'h1234; model returns 16'hBEEF. Expect:
  - gnt=0001, spi_slave_sel=0100, spi_tx_data=16'h1234, and one spi_start pulse.
  - On irq: done=0001, rsp_data=16'hBEEF, err=0.
- Contention: req=4'b1111 held from reset. Expect grants in order 0,1,2,3 then 0 again, with exactly one spi_start per grant.
- Fairness after rr_ptr=2:
  - req=4'b0011: expect grant 0 then 1.
  - Then req=4'b1001 with rr_ptr=2: expect grant 3 before 0.
- Invalid slave with NUM_SLAVES=3: req_slave[1]=3. Expect done=0010, err=1, no spi_start, spi_slave_sel=0.
- Reset mid-transfer: assert rst_n=0 in WAIT_DONE. Expect all outputs 0 immediately; after release the same pending req is re-granted starting from requester 0.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64: model never pulses irq. Expect done and err together 64 cycles after WAIT_DONE entry, rsp_data=0, and the next requester granted afterward.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master among NUM_REQ requesters.
// Optional watchdog on the completion wait: define SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_SLAVES     = 4,
    parameter int SLV_W          = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*SLV_W-1:0]      req_slave,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          err,
    output logic                          spi_start,
    output logic [DATA_WIDTH-1:0]         spi_tx_data,
    output logic [NUM_SLAVES-1:0]         spi_slave_sel,
    input  logic                          spi_busy,
    input  logic                          spi_irq,
    input  logic [DATA_WIDTH-1:0]         spi_rx_data
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      win_q, win_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  err_q, err_d;
    logic                  start_q, start_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rsp_q, rsp_d;
    logic                  irq_q;
    logic [DATA_WIDTH-1:0] rx_q;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]         cnt_q, cnt_d;
`endif

    logic                  arb_found_s;
    logic [PTR_W-1:0]      arb_win_s;
    logic [SLV_W-1:0]      arb_slv_s;
    logic [DATA_WIDTH-1:0] arb_data_s;
    logic                  arb_valid_s;

    // Round-robin search: first set req bit at or above rr_ptr, wrapping.
    always_comb begin
        arb_found_s = 1'b0;
        arb_win_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_found_s && req[PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ)]) begin
                arb_found_s = 1'b1;
                arb_win_s   = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            end else begin
                arb_found_s = arb_found_s;
            end
        end
        arb_slv_s   = req_slave[int'(arb_win_s)*SLV_W +: SLV_W];
        arb_data_s  = req_data[int'(arb_win_s)*DATA_WIDTH +: DATA_WIDTH];
        arb_valid_s = ({1'b0, arb_slv_s} < (SLV_W + 1)'(NUM_SLAVES));
    end

    // Transaction sequencer next-state logic.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        start_d  = 1'b0;
        sel_d    = sel_q;
        tx_d     = tx_q;
        rsp_d    = rsp_q;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_found_s && !spi_busy) begin
                    win_d = arb_win_s;
                    gnt_d = NUM_REQ'(1) << arb_win_s;
                    if (arb_valid_s) begin
                        tx_d    = arb_data_s;
                        sel_d   = NUM_SLAVES'(1) << arb_slv_s;
                        state_d = ST_START;
                    end else begin
                        // Unreachable slave: reject without touching the bus.
                        done_d  = NUM_REQ'(1) << arb_win_s;
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (!start_q) begin
                    start_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (irq_q) begin
                    rsp_d   = rx_q;
                    done_d  = gnt_q;
                    state_d = ST_FINISH;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_d   = '0;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
`else
                else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_FINISH: begin
                gnt_d    = '0;
                sel_d    = '0;
                rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; irq is captured only while waiting for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            sel_q    <= '0;
            tx_q     <= '0;
            rsp_q    <= '0;
            irq_q    <= 1'b0;
            rx_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            sel_q    <= sel_d;
            tx_q     <= tx_d;
            rsp_q    <= rsp_d;
            irq_q    <= spi_irq && (state_q == ST_WAIT);
            rx_q     <= spi_rx_data;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rsp_data      = rsp_q;
    assign spi_start     = start_q;
    assign spi_tx_data   = tx_q;
    assign spi_slave_sel = sel_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: vector table, hand sequences, random traffic
// against a transaction-level round-robin model and a behavioural SPI responder.
module tb_spi_master_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int NS = 3;
    localparam int SW = 2;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*SW-1:0] req_slave = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    gnt, done;
    logic [DW-1:0]    rsp_data, spi_tx_data;
    logic             err, spi_start;
    logic [NS-1:0]    spi_slave_sel;
    logic             spi_busy = 1'b0, spi_irq = 1'b0;
    logic [DW-1:0]    spi_rx_data = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    spi_master_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLV_W(SW),
                         .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_slave(req_slave), .req_data(req_data),
        .gnt(gnt), .done(done), .rsp_data(rsp_data), .err(err), .spi_start(spi_start),
        .spi_tx_data(spi_tx_data), .spi_slave_sel(spi_slave_sel), .spi_busy(spi_busy),
        .spi_irq(spi_irq), .spi_rx_data(spi_rx_data));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Behavioural SPI master: after a start, busy for a random time, then one irq pulse.
    bit irq_en = 1'b1, use_fixed = 1'b0;
    logic [DW-1:0] fixed_rsp = '0, rword = '0;
    int lat_min = 0, lat_max = 6, rcnt = 0, starts = 0, start_cyc = 0, irq_cyc = 0;
    bit ractive = 1'b0;

    function automatic logic [DW-1:0] rsp_fn(input logic [DW-1:0] t);
        return {t[7:0], t[15:8]} ^ 16'h5A5A;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            spi_busy = 1'b0; spi_irq = 1'b0; ractive = 1'b0;
        end else begin
            spi_irq = 1'b0;
            spi_rx_data = DW'($urandom);
            if (ractive) begin
                if (rcnt == 0) begin
                    spi_irq = 1'b1; spi_rx_data = rword; spi_busy = 1'b0;
                    ractive = 1'b0; irq_cyc = cyc;
                end else rcnt--;
            end
            if (spi_start) begin
                starts++; start_cyc = cyc;
                rword = use_fixed ? fixed_rsp : rsp_fn(spi_tx_data);
                ractive = irq_en; spi_busy = irq_en;
                rcnt = $urandom_range(lat_max, lat_min);
            end
        end
    end

    // Transaction-level reference: requester fields, rr pointer, last response word.
    logic [SW-1:0] slv_of [NR];
    logic [DW-1:0] dat_of [NR];
    int m_rr = 0;
    logic [DW-1:0] m_rsp = '0;

    function automatic int pick(input logic [NR-1:0] r, input int rr);
        for (int k = 0; k < NR; k++) if (r[(rr + k) % NR]) return (rr + k) % NR;
        return 0;
    endfunction

    task automatic set_fields(input int i, input logic [SW-1:0] s, input logic [DW-1:0] d);
        slv_of[i] = s; dat_of[i] = d;
        req_slave[i*SW +: SW] = s;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic wait_gnt(output bit ok);
        int n = 0;
        while (gnt == '0 && n < 400) begin step(); n++; end
        ok = (gnt != '0);
        if (!ok) begin checks++; errors++; $display("FAIL grant_wait: no grant within 400 cycles"); end
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (done == '0 && n < 400) begin step(); n++; end
        ok = (done != '0);
        if (!ok) begin checks++; errors++; $display("FAIL done_wait: no done within 400 cycles"); end
    endtask

    // One full transaction checked against the model (hard_win >= 0 pins the expected winner).
    task automatic serve(input int hard_win, input bit drop);
        int w, g_cyc, st0;
        bit valid, ok, exp_err;
        logic [DW-1:0] exp_rsp;
        st0 = starts;
        wait_gnt(ok);
        if (!ok) return;
        g_cyc = cyc;
        w = (hard_win >= 0) ? hard_win : pick(req, m_rr);
        chk("gnt", 32'(gnt), 32'(1) << w);
        valid = (slv_of[w] < NS);
        exp_err = !valid || !irq_en;
        if (valid) begin
            chk("sel", 32'(spi_slave_sel), 32'(1) << slv_of[w]);
            chk("tx", 32'(spi_tx_data), 32'(dat_of[w]));
            exp_rsp = !irq_en ? '0 : (use_fixed ? fixed_rsp : rsp_fn(dat_of[w]));
        end else begin
            chk("sel_invalid", 32'(spi_slave_sel), 32'd0);
            exp_rsp = m_rsp;
        end
        wait_done(ok);
        if (!ok) return;
        chk("done", 32'(done), 32'(1) << w);
        chk("gnt_hold", 32'(gnt), 32'(1) << w);
        chk("err", 32'(err), 32'(exp_err));
        chk("rsp", 32'(rsp_data), 32'(exp_rsp));
        chk("starts", 32'(starts - st0), valid ? 32'd1 : 32'd0);
        if (valid) begin
            chk("start_lat", 32'(start_cyc), 32'(g_cyc + 1));
            if (irq_en) chk("done_lat", 32'(cyc), 32'(irq_cyc + 2));
            else        chk("timeout_lat", 32'(cyc), 32'(start_cyc + TO + 1));
        end else begin
            chk("reject_lat", 32'(cyc), 32'(g_cyc));
        end
        m_rr = (w + 1) % NR;
        m_rsp = exp_rsp;
        if (drop) req[w] = 1'b0;
        step();
        chk("gnt_drop", 32'(gnt), 32'd0);
        chk("done_pulse", 32'(done), 32'd0);
        chk("err_pulse", 32'(err), 32'd0);
    endtask

    typedef struct {
        logic [NR-1:0] rq;
        int            win;
        logic [SW-1:0] slv;
        logic [DW-1:0] dat;
        logic [DW-1:0] srsp;
        logic [NS-1:0] exp_sel;
        logic          exp_err;
        logic [DW-1:0] exp_rsp;
    } vec_t;

    vec_t vt [6];

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_start"}, 32'(spi_start), 32'd0);
        chk({tag, "_sel"}, 32'(spi_slave_sel), 32'd0);
        chk({tag, "_tx"}, 32'(spi_tx_data), 32'd0);
        chk({tag, "_rsp"}, 32'(rsp_data), 32'd0);
    endtask

    initial begin
        bit ok;
        vt[0] = '{4'b0001, 0, 2'd2, 16'h1234, 16'hBEEF, 3'b100, 1'b0, 16'hBEEF};
        vt[1] = '{4'b0010, 1, 2'd3, 16'h1111, 16'h0000, 3'b000, 1'b1, 16'hBEEF};
        vt[2] = '{4'b0100, 2, 2'd0, 16'hA5A5, 16'h0F0F, 3'b001, 1'b0, 16'h0F0F};
        vt[3] = '{4'b1000, 3, 2'd1, 16'hFFFF, 16'h8001, 3'b010, 1'b0, 16'h8001};
        vt[4] = '{4'b1000, 3, 2'd3, 16'h2222, 16'h0000, 3'b000, 1'b1, 16'h8001};
        vt[5] = '{4'b0001, 0, 2'd1, 16'h0000, 16'hFFFF, 3'b010, 1'b0, 16'hFFFF};

        // Contention: all four request from reset with valid slaves.
        for (int i = 0; i < NR; i++) set_fields(i, SW'($urandom_range(NS - 1, 0)), DW'($urandom));
        req = 4'b1111;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        serve(0, 1'b0); serve(1, 1'b0); serve(2, 1'b0); serve(3, 1'b0); serve(0, 1'b0);
        req = '0;
        repeat (3) step();

        // Vector table of single-requester transactions.
        use_fixed = 1'b1;
        for (int v = 0; v < 6; v++) begin
            set_fields(vt[v].win, vt[v].slv, vt[v].dat);
            fixed_rsp = vt[v].srsp;
            req = vt[v].rq;
            wait_gnt(ok);
            if (!ok) continue;
            chk("vec_gnt", 32'(gnt), 32'(vt[v].rq));
            chk("vec_sel", 32'(spi_slave_sel), 32'(vt[v].exp_sel));
            if (!vt[v].exp_err) chk("vec_tx", 32'(spi_tx_data), 32'(vt[v].dat));
            wait_done(ok);
            if (!ok) continue;
            chk("vec_done", 32'(done), 32'(vt[v].rq));
            chk("vec_err", 32'(err), 32'(vt[v].exp_err));
            chk("vec_rsp", 32'(rsp_data), 32'(vt[v].exp_rsp));
            req = '0;
            step();
            chk("vec_gnt_drop", 32'(gnt), 32'd0);
        end
        m_rr = 1; m_rsp = 16'hFFFF;
        use_fixed = 1'b0;

        // Fairness: bring rr to 2, then 0011 -> 0,1 and 1001 -> 3,0.
        set_fields(1, 2'd0, 16'h3C3C);
        req = 4'b0010; serve(1, 1'b1);
        set_fields(0, 2'd1, 16'h0101); set_fields(1, 2'd2, 16'h0202);
        req = 4'b0011; serve(0, 1'b1); serve(1, 1'b1);
        set_fields(3, 2'd0, 16'h0303); set_fields(0, 2'd2, 16'h0404);
        req = 4'b1001; serve(3, 1'b1); serve(0, 1'b1);

        // Reset during WAIT_DONE, then the pending requests re-arbitrate from requester 0.
        set_fields(2, 2'd1, 16'h5555);
        req = 4'b0100; serve(2, 1'b1);
        set_fields(1, 2'd2, 16'h6666); set_fields(3, 2'd0, 16'h7777);
        lat_min = 30; lat_max = 30;
        req = 4'b1010;
        wait_gnt(ok);
        chk("pre_reset_gnt", 32'(gnt), 32'b1000);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        m_rr = 0; m_rsp = '0;
        lat_min = 0; lat_max = 6;
        step();
        rst_n = 1'b1;
        serve(1, 1'b1); serve(3, 1'b1);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: responder never completes.
        irq_en = 1'b0;
        set_fields(0, 2'd1, 16'h0A0A); set_fields(1, 2'd2, 16'h0B0B);
        req = 4'b0011;
        serve(-1, 1'b1); serve(-1, 1'b1);
        irq_en = 1'b1;
`endif

        // Random traffic: requesters join randomly and hold until their done.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && ($urandom_range(1, 0) == 1)) begin
                    set_fields(i, SW'($urandom_range(3, 0)), DW'($urandom));
                    req[i] = 1'b1;
                end
            end
            if (req == '0) begin
                set_fields(t % NR, SW'($urandom_range(3, 0)), DW'($urandom));
                req[t % NR] = 1'b1;
            end
            serve(-1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
